// File: rtl/icache_pkg.sv
// Shared types, block-geometry constants and address-split helpers for the
// instruction cache fetch unit.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT
    } fill_state_t;

    localparam int unsigned WORDS_PER_BLK = 8;
    localparam int unsigned OFFSET_W      = 3;
    localparam int unsigned BLK_BYTES     = 16;

    // Index field sits just above the 16-byte block offset.
    function automatic logic [15:0] get_index(input logic [15:0] addr, input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return 16'(({16'd0, addr} >> 4) & mask);
    endfunction

    function automatic logic [15:0] get_tag(input logic [15:0] addr, input int unsigned idx_w);
        return 16'({16'd0, addr} >> (4 + idx_w));
    endfunction

endpackage

// File: rtl/icache_fill_fsm.sv
// Block-fill sequencer: latches the missing block address, issues eight word
// reads as the arbiter grants the port, and counts the in-order returns.
module icache_fill_fsm
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                miss,
    input  logic [15:0]         blk_addr,
    input  logic                mem_grant,
    input  logic                mem_data_valid,
    output logic                busy,
    output logic [15:0]         miss_addr,
    output logic                mem_en,
    output logic [15:0]         mem_addr,
    output logic                data_we,
    output logic [OFFSET_W-1:0] data_word,
    output logic                tag_we
);

    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_BLK - 1);

    fill_state_t         state;
    logic [OFFSET_W-1:0] issue_cnt;
    logic [OFFSET_W-1:0] recv_cnt;
    logic                fill_active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            miss_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        miss_addr <= blk_addr;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (mem_grant) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == LAST_WORD) state <= WAIT;
                    end
                    // Returns can overlap issue; the final return wins the state update.
                    if (mem_data_valid) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (recv_cnt == LAST_WORD) state <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_data_valid) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (recv_cnt == LAST_WORD) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        fill_active = (state == FILL);
        mem_en      = fill_active & mem_grant;
        mem_addr    = fill_active ? (miss_addr + 16'({issue_cnt, 1'b0})) : '0;
        data_we     = busy & mem_data_valid;
        data_word   = recv_cnt;
        tag_we      = data_we & (recv_cnt == LAST_WORD);
    end

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache in front of IF: combinational hit path,
// stall-and-fill on miss through the shared memory port.
module icache_fetch_unit
    import icache_pkg::get_index, icache_pkg::get_tag, icache_pkg::OFFSET_W;
#(
    parameter int unsigned NUM_SETS      = 64,
    parameter int unsigned WORDS_PER_BLK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        fetch_en,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic        stall,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    input  logic        mem_grant,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 16 - 4 - IDX_W;

    logic [15:0]         data_arr [NUM_SETS][WORDS_PER_BLK];
    logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
    logic [NUM_SETS-1:0] valid;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] offset;
    logic                hit;
    logic                busy;
    logic [15:0]         miss_addr;
    logic [IDX_W-1:0]    miss_idx;
    logic [TAG_W-1:0]    miss_tag;
    logic                data_we;
    logic [OFFSET_W-1:0] data_word;
    logic                tag_we;

    always_comb begin
        idx        = IDX_W'(get_index(pc, IDX_W));
        tag        = TAG_W'(get_tag(pc, IDX_W));
        offset     = pc[3:1];
        miss_idx   = IDX_W'(get_index(miss_addr, IDX_W));
        miss_tag   = TAG_W'(get_tag(miss_addr, IDX_W));
        hit        = fetch_en & valid[idx] & (tag_arr[idx] == tag);
        stall      = busy | (fetch_en & ~hit);
        inst_valid = hit & ~busy;
        inst       = inst_valid ? data_arr[idx][offset] : '0;
    end

    icache_fill_fsm u_fill_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss           (fetch_en & ~hit),
        .blk_addr       ({pc[15:4], 4'b0000}),
        .mem_grant      (mem_grant),
        .mem_data_valid (mem_data_valid),
        .busy           (busy),
        .miss_addr      (miss_addr),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .data_we        (data_we),
        .data_word      (data_word),
        .tag_we         (tag_we)
    );

    // Arrays keep their contents across reset; only valid bits are cleared,
    // and a reset edge must not let an in-flight return land in the array.
    always_ff @(posedge clk) begin
        if (rst_n && data_we) data_arr[miss_idx][data_word] <= mem_data;
        if (rst_n && tag_we)  tag_arr[miss_idx]             <= miss_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[miss_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Randomized scoreboard bench for icache_fetch_unit against a line-presence
// model and a latency-4 in-order memory responder.
module tb_icache_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = '0;
    logic        fetch_en = 1'b0;
    logic [15:0] inst;
    logic        inst_valid;
    logic        stall;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_grant = 1'b1;
    logic [15:0] mem_data = '0;
    logic        mem_data_valid = 1'b0;

    icache_fetch_unit #(.NUM_SETS(64), .WORDS_PER_BLK(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .fetch_en       (fetch_en),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .stall          (stall),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .mem_grant      (mem_grant),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid)
    );

    always #5 clk = ~clk;

    localparam int LAT = 4;

    typedef struct {
        logic [15:0] inst;
        bit          miss;
        int          exp_stall;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } ret_t;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          grant_mode = 0;
    bit          stray_en = 1'b0;
    int          ret_seen = 0;
    int          stall_cnt = 0;
    exp_t        sb_q[$];
    logic [15:0] addr_q[$];
    ret_t        ret_q[$];
    bit          model_valid[64];
    logic [5:0]  model_tag[64];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[6:0], a[15:7]} ^ 16'hC35A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        case (grant_mode)
            0:       mem_grant = 1'b1;
            1:       mem_grant = ~mem_grant;
            default: mem_grant = 1'($urandom_range(0, 1));
        endcase
    end

    // Memory: each granted request returns LAT cycles later, in order.
    initial forever begin
        @(posedge clk);
        #1;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            ret_t r;
            r = ret_q.pop_front();
            mem_data_valid = 1'b1;
            mem_data       = mem_word(r.addr);
            ret_seen++;
        end else if (stray_en) begin
            mem_data_valid = 1'b1;
            mem_data       = 16'($urandom);
        end else begin
            mem_data_valid = 1'b0;
            mem_data       = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            check("issue_when_granted", 32'(mem_grant), 1);
            check("issue_expected", 32'(addr_q.size() > 0), 1);
            if (addr_q.size() > 0) check("issue_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            ret_q.push_back('{addr: mem_addr, due: cyc + LAT});
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            stall_cnt = 0;
        end else begin
            if (fetch_en && stall) stall_cnt++;
            if (stall || !fetch_en) begin
                check("inst_zero_when_idle", 32'({inst, 15'd0, inst_valid}), 0);
            end
            if (inst_valid) begin
                check("valid_has_entry", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("inst", 32'(inst), 32'(e.inst));
                    if (e.exp_stall >= 0) check("stall_cycles", 32'(stall_cnt), 32'(e.exp_stall));
                    else                  check("miss_stalled", 32'(stall_cnt > 0), 32'(e.miss));
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic start_fetch(input logic [15:0] a, input int gmode);
        int         idx;
        logic [5:0] tg;
        exp_t       e;
        idx         = int'(a[9:4]);
        tg          = a[15:10];
        e.miss      = !(model_valid[idx] && model_tag[idx] == tg);
        e.inst      = mem_word({a[15:1], 1'b0});
        e.exp_stall = !e.miss ? 0 : (gmode == 0 ? 13 : -1);
        sb_q.push_back(e);
        if (e.miss) begin
            for (int i = 0; i < 8; i++) addr_q.push_back({a[15:4], 4'b0000} + 16'(2 * i));
            model_valid[idx] = 1'b1;
            model_tag[idx]   = tg;
        end
        grant_mode = gmode;
        pc         = a;
        fetch_en   = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (inst_valid) break;
        end
        check("fetch_done", 32'(inst_valid), 1);
        check("all_issued", 32'(addr_q.size()), 0);
    endtask

    task automatic fetch(input logic [15:0] a, input int gmode);
        @(posedge clk);
        #1;
        start_fetch(a, gmode);
        wait_done();
    endtask

    task automatic check_quiet(input string name);
        check(name, 32'({stall, mem_en, inst_valid, inst, mem_addr}), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        addr_q.delete();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int base;
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cold cache with fetch disabled: nothing happens.
        pc = 16'h1234;
        repeat (4) begin
            @(negedge clk);
            check_quiet("fetch_en_low_quiet");
        end

        // Cold fetch, then the remaining seven words of the block hit.
        fetch(16'h0000, 0);
        for (int w = 1; w < 8; w++) fetch(16'(2 * w), 0);

        // Same index, different tag: eviction and re-miss.
        fetch(16'h0010, 0);
        fetch(16'h0416, 0);
        fetch(16'h0010, 0);

        // Throttled grant, then hits on the filled line; top-of-memory block.
        fetch(16'h0124, 1);
        fetch(16'h0120, 0);
        fetch(16'h012E, 0);
        fetch(16'hFFFE, 1);
        fetch(16'hFFF0, 0);

        // Abort a fill after three returns.
        @(posedge clk);
        #1;
        base = ret_seen;
        start_fetch(16'h0230, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ret_seen - base >= 3) break;
        end
        check("three_returns", 32'(ret_seen - base >= 3), 1);
        do_reset();
        @(negedge clk);
        check_quiet("after_reset_quiet");
        stray_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_quiet("stray_ignored");
        end
        stray_en = 1'b0;
        for (int i = 0; i < 50 && ret_q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_quiet("late_returns_ignored");
        fetch(16'h0230, 0);
        fetch(16'h0010, 0);

        // Randomized mix over a few tags and sets to force hits and evictions.
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            a = {4'd0, 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
                fetch_en = 1'b0;
                @(negedge clk);
                check_quiet("gap_quiet");
            end
            fetch(a, int'($urandom_range(0, 2)));
        end

        @(posedge clk);
        #1;
        fetch_en = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
